booth_mul_arbiter: RTL and testbench

Shares one pipelined 32x32->64 unsigned Booth multiplier (`Booth_mul`) among N requesters. Accepts operand pairs over per-requester valid/ready handshakes, issues at most one operation per cycle via round-robin arbitration, and tags each issue with its requester ID. Returns products in issue order through a backpressured response port. A credit counter guarantees that no product is ever dropped. The block sits between the client units and the `Booth_mul` instance, and drives that instance's `A`/`B` inputs directly.

---
 rtl/booth_arb_pkg.sv | 46 ++++
 rtl/booth_arb_fifo.sv | 67 ++++++
 rtl/booth_mul_arbiter.sv | 118 +++++++++++
 tb/tb_booth_mul_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/booth_arb_pkg.sv
// rtl/booth_arb_pkg.sv - shared types and round-robin helper for the Booth multiplier arbiter
//
// Purpose : widths, tag/response structs and the round-robin pick function
//           used by booth_mul_arbiter and booth_arb_fifo.
// Ports   : none (package).
package booth_arb_pkg;

  localparam int DATA_W  = 32;
  localparam int PROD_W  = 64;
  localparam int MAX_REQ = 8;
  // ID field sized for the largest supported requester count; the top
  // exposes only the low clog2(N_REQ) bits.
  localparam int ID_W    = 3;

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } tag_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [PROD_W-1:0] p;
  } rsp_t;

  // Returns {found, index}. The search starts at ptr+1 and wraps modulo n.
  // The loop has a constant bound so it unrolls cleanly; n is a parameter
  // at every call site, so the modulo folds away.
  function automatic logic [ID_W:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                            input logic [ID_W-1:0]    ptr,
                                            input int                 n);
    logic            found;
    logic [ID_W-1:0] idx;
    int              j;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= MAX_REQ; i++) begin
      j = (int'(ptr) + i) % n;
      if (i <= n && !found && req[j]) begin
        found = 1'b1;
        idx   = ID_W'(j);
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/booth_arb_fifo.sv
// rtl/booth_arb_fifo.sv - show-ahead sync FIFO with registered head outputs
//
// Purpose : storage array plus a head register. A push lands in the array
//           and reaches the head register on the following edge, so a push
//           into an empty FIFO is visible one cycle later.
// Ports   : clk, rst        - clock, synchronous active-high reset
//           push, push_data - write strobe and data
//           pop             - consume head (ignored when out_valid is 0)
//           out_valid       - head register holds an entry
//           out_data        - head entry (0 after reset)
//           count           - entries held (array + head register)
module booth_arb_fifo #(
  parameter int WIDTH = 67,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+2)-1:0] count
);

  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 2);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0] mem_cnt;
  logic             load;

  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Refill the head from the array whenever the head is empty or leaving.
  // mem_cnt is the registered count, so a same-edge push is not forwarded.
  assign load  = (mem_cnt != '0) && (!out_valid || pop);
  assign count = mem_cnt + CNT_W'(out_valid);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_cnt   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (load) begin
        out_data  <= mem[rd_ptr];
        out_valid <= 1'b1;
        rd_ptr    <= ptr_next(rd_ptr);
      end else if (pop) begin
        out_valid <= 1'b0;
      end
      mem_cnt <= mem_cnt + CNT_W'(push) - CNT_W'(load);
    end
  end

endmodule

// File: rtl/booth_mul_arbiter.sv
// rtl/booth_mul_arbiter.sv - round-robin front end sharing one pipelined Booth multiplier
//
// Purpose : arbitrates N_REQ requesters onto one Booth_mul, tags each issue
//           with its requester ID and returns products in issue order.
//           A credit counter (in-flight + queued) keeps the FIFO from
//           ever overflowing.
// Ports   : sys_clk, sys_rst      - clock, synchronous active-high reset
//           req_valid/a/b/ready   - per-requester operand handshake
//           mul_a, mul_b, mul_p   - registered operands to / product from Booth_mul
//           rsp_valid/id/p/ready  - backpressured response port
//           busy                  - credit count non-zero
module booth_mul_arbiter
  import booth_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int MUL_LAT    = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_a,
  input  logic [N_REQ*DATA_W-1:0]   req_b,
  output logic [N_REQ-1:0]          req_ready,
  output logic [DATA_W-1:0]         mul_a,
  output logic [DATA_W-1:0]         mul_b,
  input  logic [PROD_W-1:0]         mul_p,
  output logic                      rsp_valid,
  output logic [$clog2(N_REQ)-1:0]  rsp_id,
  output logic [PROD_W-1:0]         rsp_p,
  input  logic                      rsp_ready,
  output logic                      busy
);

  localparam int CW    = $clog2(FIFO_DEPTH + 1);
  localparam int RID_W = $clog2(N_REQ);
  localparam int FC_W  = $clog2(FIFO_DEPTH + 2);

  logic [CW-1:0]     credit_cnt;
  logic [ID_W-1:0]   rr_ptr;
  tag_t              tag_pipe [MUL_LAT];
  logic [ID_W:0]     pick;
  logic              found, accept, pop, push;
  logic [ID_W-1:0]   win;
  logic [DATA_W-1:0] sel_a, sel_b;
  rsp_t              push_rsp, head;
  logic [FC_W-1:0]   fifo_count;
  logic              unused_bits;

  // The limit uses the registered credit, so a pop in this cycle cannot
  // fund an issue in the same cycle.
  assign pick   = rr_pick(MAX_REQ'(req_valid), rr_ptr, N_REQ);
  assign found  = pick[ID_W];
  assign win    = pick[ID_W-1:0];
  assign accept = found && (credit_cnt < CW'(FIFO_DEPTH));
  assign pop    = rsp_valid && rsp_ready;
  assign push   = tag_pipe[MUL_LAT-1].vld;
  assign busy   = (credit_cnt != '0);

  always_comb begin
    req_ready = '0;
    sel_a     = '0;
    sel_b     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win == ID_W'(i)) begin
        req_ready[i] = accept;
        sel_a        = req_a[i*DATA_W +: DATA_W];
        sel_b        = req_b[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      mul_a      <= '0;
      mul_b      <= '0;
      rr_ptr     <= ID_W'(N_REQ - 1);
      credit_cnt <= '0;
      for (int i = 0; i < MUL_LAT; i++) tag_pipe[i] <= '0;
    end else begin
      // Idle cycles drive zero operands so Booth_mul sees a defined input.
      mul_a       <= accept ? sel_a : '0;
      mul_b       <= accept ? sel_b : '0;
      tag_pipe[0] <= '{vld: accept, id: (accept ? win : '0)};
      for (int i = 1; i < MUL_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
      if (accept) rr_ptr <= win;
      case ({accept, pop})
        2'b10:   credit_cnt <= credit_cnt + 1'b1;
        2'b01:   credit_cnt <= credit_cnt - 1'b1;
        default: credit_cnt <= credit_cnt;
      endcase
    end
  end

  assign push_rsp = '{id: tag_pipe[MUL_LAT-1].id, p: mul_p};

  booth_arb_fifo #(
    .WIDTH ($bits(rsp_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (sys_clk),
    .rst       (sys_rst),
    .push      (push),
    .push_data (push_rsp),
    .pop       (pop),
    .out_valid (rsp_valid),
    .out_data  (head),
    .count     (fifo_count)
  );

  assign rsp_p  = head.p;
  assign rsp_id = head.id[RID_W-1:0];

  // Occupancy is tracked by the credit counter; the FIFO count and unused
  // high ID bits are intentionally not consumed.
  assign unused_bits = ^{fifo_count, head.id};

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// tb/tb_booth_mul_arbiter.sv - directed and random checks for booth_mul_arbiter
module tb_booth_mul_arbiter;

  localparam int N     = 4;
  localparam int LAT   = 4;
  localparam int DEPTH = 8;

  logic          sys_clk = 1'b0;
  logic          sys_rst;
  logic [N-1:0]  req_valid;
  logic [N*32-1:0] req_a, req_b;
  logic [N-1:0]  req_ready;
  logic [31:0]   mul_a, mul_b;
  logic [63:0]   mul_p;
  logic          rsp_valid;
  logic [1:0]    rsp_id;
  logic [63:0]   rsp_p;
  logic          rsp_ready;
  logic          busy;

  always #5 sys_clk = ~sys_clk;

  booth_mul_arbiter #(.N_REQ(N), .MUL_LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_p     (mul_p),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_p     (rsp_p),
    .rsp_ready (rsp_ready),
    .busy      (busy)
  );

  // Booth_mul stand-in: the mul_a/mul_b register plus LAT-1 further stages.
  logic [63:0] mpipe [LAT-1];
  always @(posedge sys_clk) begin
    mpipe[0] <= 64'(mul_a) * 64'(mul_b);
    for (int i = 1; i < LAT - 1; i++) mpipe[i] <= mpipe[i-1];
  end
  assign mul_p = mpipe[LAT-2];

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          sb_id[$];
  logic [63:0] sb_p[$];
  int          acc_cnt, rsp_cnt, first_rsp_cyc, last_rsp_cyc, first_acc_cyc;
  int          exp_rr, stale_cnt;
  logic        track_rr = 1'b0;
  logic        chk_busy = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    int idx;
    #1;
    if (|req_ready) begin
      check("grant_onehot", 64'($countones(req_ready)), 64'd1);
      idx = 0;
      for (int i = 0; i < N; i++) if (req_ready[i]) idx = i;
      sb_id.push_back(idx);
      sb_p.push_back(64'(req_a[idx*32 +: 32]) * 64'(req_b[idx*32 +: 32]));
      acc_cnt++;
      if (first_acc_cyc < 0) first_acc_cyc = cyc;
      if (track_rr) begin
        check("rr_order", 64'(idx), 64'(exp_rr));
        exp_rr = (exp_rr + 1) % N;
      end
    end
    if (chk_busy) check("busy_high", 64'(busy), 64'd1);
    if (rsp_valid && rsp_ready) begin
      if (sb_id.size() == 0) begin
        check("rsp_spurious", 64'(rsp_valid), 64'd0);
      end else begin
        check("rsp_id", 64'(rsp_id), 64'(sb_id.pop_front()));
        check("rsp_p", rsp_p, sb_p.pop_front());
      end
      rsp_cnt++;
      if (first_rsp_cyc < 0) first_rsp_cyc = cyc;
      last_rsp_cyc = cyc;
    end
    @(posedge sys_clk);
    #1;
    cyc++;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
  endtask

  task automatic drain(input string tag);
    int t = 0;
    while (sb_id.size() != 0 && t < 60) begin
      tick();
      t++;
    end
    check(tag, 64'(sb_id.size()), 64'd0);
  endtask

  task automatic single(input int id, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp_p);
    int lat;
    set_req(id, a, b);
    req_valid = N'(1 << id);
    #1;
    check("single_grant", 64'(req_ready), 64'(1 << id));
    tick();
    req_valid = '0;
    check("single_mul_a", 64'(mul_a), 64'(a));
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("single_latency", 64'(lat), 64'(LAT + 1));
    check("single_rsp_p", rsp_p, exp_p);
    check("single_rsp_id", 64'(rsp_id), 64'(id));
    tick();
  endtask

  task automatic clear_stats();
    acc_cnt = 0; rsp_cnt = 0; first_rsp_cyc = -1; last_rsp_cyc = -1; first_acc_cyc = -1;
  endtask

  initial begin
    sys_rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    clear_stats();
    repeat (3) tick();
    sys_rst = 1'b0;
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_mul_a", 64'(mul_a), 64'd0);
    check("rst_mul_b", 64'(mul_b), 64'd0);
    check("rst_rsp_p", rsp_p, 64'd0);
    check("rst_rsp_id", 64'(rsp_id), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);

    // Single ops and extreme operands
    single(2, 32'h0000_0003, 32'h0000_0005, 64'h0000_0000_0000_000F);
    single(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    single(1, 32'h0000_0000, 32'hFFFF_FFFF, 64'h0);

    // All four requesters continuously valid; pointer last moved to 1
    for (int i = 0; i < N; i++) set_req(i, 32'(i + 1), 32'h100);
    clear_stats();
    req_valid = '1; track_rr = 1'b1; exp_rr = 2;
    tick();
    chk_busy = 1'b1;
    repeat (15) tick();
    req_valid = '0; track_rr = 1'b0; chk_busy = 1'b0;
    drain("rr_drain");
    check("rr_rsp_count", 64'(rsp_cnt), 64'd16);
    check("rr_contiguous", 64'(last_rsp_cyc - first_rsp_cyc), 64'd15);
    check("rr_busy_idle", 64'(busy), 64'd0);

    // Backpressure: credit stops issue at DEPTH
    clear_stats();
    rsp_ready = 1'b0; req_valid = '1;
    repeat (20) tick();
    check("bp_accepts", 64'(acc_cnt), 64'(DEPTH));
    check("bp_req_ready", 64'(req_ready), 64'd0);
    check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
    check("bp_busy", 64'(busy), 64'd1);

    // Release: queued entries drain in order while issue resumes
    clear_stats();
    rsp_ready = 1'b1;
    repeat (24) tick();
    check("bp_resume", 64'(first_acc_cyc - first_rsp_cyc), 64'd1);
    check("bp_stream_count", 64'(rsp_cnt), 64'd24);
    check("bp_stream_contig", 64'(last_rsp_cyc - first_rsp_cyc), 64'd23);
    req_valid = '0;
    drain("bp_drain");

    // Reset with 2 queued and 3 in flight
    rsp_ready = 1'b0; req_valid = '1;
    repeat (2) tick();
    req_valid = '0;
    repeat (6) tick();
    req_valid = '1;
    repeat (3) tick();
    sys_rst = 1'b1; req_valid = '0;
    tick();
    sys_rst = 1'b0;
    sb_id.delete(); sb_p.delete();
    check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_mul_a", 64'(mul_a), 64'd0);
    rsp_ready = 1'b1;
    stale_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (rsp_valid) stale_cnt++;
      tick();
    end
    check("mid_rst_no_stale", 64'(stale_cnt), 64'd0);
    req_valid = '1;
    #1;
    check("mid_rst_first_grant", 64'(req_ready), 64'd1);
    req_valid = '0;

    // Random traffic
    clear_stats();
    for (int t = 0; t < 12000 && acc_cnt < 2000; t++) begin
      req_valid = N'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 7))
          0:       set_req(i, 32'hFFFF_FFFF, $urandom);
          1:       set_req(i, 32'h0, $urandom);
          default: set_req(i, $urandom, $urandom);
        endcase
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    check("rand_accepts", 64'(acc_cnt >= 2000), 64'd1);
    req_valid = '0; rsp_ready = 1'b1;
    drain("rand_drain");
    tick();
    check("rand_busy_idle", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
